// File: rtl/gbdt_tree_walker.sv
// rtl/gbdt_tree_walker.sv - GBDT evaluation stage: walks 8 binary trees and sums their leaf scores
//
// Purpose:
//   Holds per-tree node tables (feature index + 9-bit threshold) and leaf tables
//   (signed scores). On start, all 8 trees step down one level per cycle.
//   Each step uses the feature store readout returned for the indices driven
//   on features_nums. After DEPTH levels, the selected leaves are summed into
//   one signed prediction. The prediction is offered on a valid/ready handshake.
//
// Ports:
//   gbdt_clk, gbdt_rst_n        clock, asynchronous active-low reset (clears tables too)
//   cfg_we/cfg_leaf/cfg_tree/
//   cfg_addr/cfg_data           table write port, honoured only in IDLE or DONE
//   start                       begin an evaluation (IDLE only, never queued)
//   features_nums[t]            feature index requested for tree t
//   features_vals[t]            combinational feature store readout for tree t
//   busy                        high in WALK and SUM
//   result_valid/result_ready   prediction handshake
//   result                      signed sum of the 8 selected leaf scores

module gbdt_tree_walker #(
  parameter int DEPTH  = 4,
  parameter int LEAF_W = 16,
  parameter int SUM_W  = LEAF_W + 3,
  localparam int CFG_W = (LEAF_W > 17) ? LEAF_W : 17
) (
  input  logic                    gbdt_clk,
  input  logic                    gbdt_rst_n,
  input  logic                    cfg_we,
  input  logic                    cfg_leaf,
  input  logic [2:0]              cfg_tree,
  input  logic [DEPTH-1:0]        cfg_addr,
  input  logic [CFG_W-1:0]        cfg_data,
  input  logic                    start,
  output logic [7:0][7:0]         features_nums,
  input  logic [7:0][8:0]         features_vals,
  output logic                    busy,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic signed [SUM_W-1:0] result
);

  localparam int NODES  = (1 << DEPTH) - 1;
  localparam int LEAVES = 1 << DEPTH;
  localparam int IDX_W  = DEPTH + 1;
  localparam int LVL_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    WALK,
    SUM,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        node_feat [8][NODES];
  logic [8:0]        node_thr  [8][NODES];
  logic [LEAF_W-1:0] leaf_val  [8][LEAVES];

  // node_idx uses heap numbering over the whole tree: internal nodes 0..NODES-1,
  // leaves NODES..2*NODES, so one extra bit is needed past the last level.
  logic [IDX_W-1:0]  node_idx [8];
  logic [LVL_W-1:0]  level_q;

  logic [DEPTH-1:0]  cur_node [8];
  logic [7:0]        go_right;
  logic [DEPTH-1:0]  leaf_sel [8];
  logic [LEAF_W-1:0] leaf_pick [8];
  logic signed [SUM_W-1:0] leaf_sum;

  logic cfg_ok;
  logic node_addr_ok;

  assign cfg_ok       = cfg_we && ((state_q == IDLE) || (state_q == DONE));
  assign node_addr_ok = (cfg_addr != DEPTH'(NODES));
  assign busy         = (state_q == WALK) || (state_q == SUM);

  // ------------------------------------------------------------------
  // Node and leaf tables
  // ------------------------------------------------------------------
  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      for (int t = 0; t < 8; t++) begin
        for (int n = 0; n < NODES; n++) begin
          node_feat[t][n] <= '0;
          node_thr[t][n]  <= '0;
        end
        for (int l = 0; l < LEAVES; l++) begin
          leaf_val[t][l] <= '0;
        end
      end
    end else if (cfg_ok) begin
      if (cfg_leaf) begin
        leaf_val[cfg_tree][cfg_addr] <= cfg_data[LEAF_W-1:0];
      end else if (node_addr_ok) begin
        node_feat[cfg_tree][cfg_addr] <= cfg_data[16:9];
        node_thr[cfg_tree][cfg_addr]  <= cfg_data[8:0];
      end
    end
  end

  // ------------------------------------------------------------------
  // Per-tree lookup and compare
  // Outside WALK the trees present their root so the store already sees the
  // first-level indices; features_nums depends only on registered state.
  // ------------------------------------------------------------------
  always_comb begin
    for (int t = 0; t < 8; t++) begin
      cur_node[t]      = (state_q == WALK) ? node_idx[t][DEPTH-1:0] : '0;
      features_nums[t] = node_feat[t][cur_node[t]];
      // Unsigned compare; equality goes left.
      go_right[t]      = (features_vals[t] > node_thr[t][cur_node[t]]);
      leaf_sel[t]      = DEPTH'(node_idx[t] - IDX_W'(NODES));
      leaf_pick[t]     = leaf_val[t][leaf_sel[t]];
    end
  end

  always_comb begin
    leaf_sum = '0;
    for (int t = 0; t < 8; t++) begin
      leaf_sum = leaf_sum + {{(SUM_W-LEAF_W){leaf_pick[t][LEAF_W-1]}}, leaf_pick[t]};
    end
  end

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------
  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = WALK;
      WALK: if (level_q == LVL_W'(DEPTH - 1)) state_d = SUM;
      SUM:  state_d = DONE;
      DONE: if (result_valid && result_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Walk / sum datapath
  // ------------------------------------------------------------------
  always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
    if (!gbdt_rst_n) begin
      level_q      <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      for (int t = 0; t < 8; t++) begin
        node_idx[t] <= '0;
      end
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            level_q <= '0;
            for (int t = 0; t < 8; t++) begin
              node_idx[t] <= '0;
            end
          end
        end
        WALK: begin
          // The counter wraps after the last level; it is reloaded on start.
          level_q <= level_q + LVL_W'(1);
          for (int t = 0; t < 8; t++) begin
            node_idx[t] <= {node_idx[t][DEPTH-1:0], 1'b0} + IDX_W'(1) + IDX_W'(go_right[t]);
          end
        end
        SUM: begin
          result       <= leaf_sum;
          result_valid <= 1'b1;
        end
        DONE: begin
          if (result_valid && result_ready) begin
            result_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gbdt_tree_walker.sv
// tb/tb_gbdt_tree_walker.sv - directed self-checking bench for gbdt_tree_walker

module tb_gbdt_tree_walker;

  logic                gbdt_clk = 1'b0;
  logic                gbdt_rst_n;
  logic                cfg_we;
  logic                cfg_leaf;
  logic [2:0]          cfg_tree;
  logic [3:0]          cfg_addr;
  logic [16:0]         cfg_data;
  logic                start;
  logic [7:0][7:0]     features_nums;
  logic [7:0][8:0]     features_vals;
  logic                busy;
  logic                result_valid;
  logic                result_ready;
  logic signed [18:0]  result;

  int checks = 0;
  int errors = 0;

  logic [8:0]      fs [256];
  logic [7:0][7:0] feat_hist [4];

  gbdt_tree_walker #(.DEPTH(4), .LEAF_W(16)) dut (
    .gbdt_clk      (gbdt_clk),
    .gbdt_rst_n    (gbdt_rst_n),
    .cfg_we        (cfg_we),
    .cfg_leaf      (cfg_leaf),
    .cfg_tree      (cfg_tree),
    .cfg_addr      (cfg_addr),
    .cfg_data      (cfg_data),
    .start         (start),
    .features_nums (features_nums),
    .features_vals (features_vals),
    .busy          (busy),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .result        (result)
  );

  always #5 gbdt_clk = ~gbdt_clk;

  // Combinational feature store.
  always_comb begin
    for (int t = 0; t < 8; t++) begin
      features_vals[t] = fs[features_nums[t]];
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cfg_write(input bit lf, input int tr, input int ad, input int dat);
    cfg_we   = 1'b1;
    cfg_leaf = lf;
    cfg_tree = 3'(tr);
    cfg_addr = 4'(ad);
    cfg_data = 17'(dat);
    @(negedge gbdt_clk);
    cfg_we   = 1'b0;
  endtask

  task automatic node_write(input int tr, input int n, input int feat, input int thr);
    cfg_write(1'b0, tr, n, (feat << 9) | thr);
  endtask

  task automatic leaf_write(input int tr, input int l, input int val);
    cfg_write(1'b1, tr, l, val & 32'hFFFF);
  endtask

  // Called at a negedge; returns at the negedge where result_valid was seen.
  task automatic run_eval(output logic signed [18:0] res, output int lat, output int bcnt);
    start = 1'b1;
    @(negedge gbdt_clk);
    start = 1'b0;
    lat  = -1;
    bcnt = 0;
    res  = '0;
    for (int j = 0; j < 20; j++) begin
      if (j < 4) feat_hist[j] = features_nums;
      if (result_valid) begin
        lat = j;
        res = result;
        break;
      end
      if (busy) bcnt++;
      @(negedge gbdt_clk);
    end
  endtask

  task automatic setup_equal();
    for (int i = 0; i < 256; i++) fs[i] = 9'd0;
    for (int n = 0; n < 15; n++) begin
      node_write(0, n, n, 10 + n);
      fs[n] = 9'(10 + n);
      node_write(1, n, 100 + n, 20 + n);
      fs[100 + n] = 9'(21 + n);
    end
    leaf_write(0, 0, 1234);
    leaf_write(0, 15, 7000);
    leaf_write(1, 15, -34);
    leaf_write(1, 0, 5000);
  endtask

  task automatic test_reset();
    logic signed [18:0] res;
    int lat, bcnt;
    gbdt_rst_n   = 1'b0;
    cfg_we       = 1'b0;
    cfg_leaf     = 1'b0;
    cfg_tree     = '0;
    cfg_addr     = '0;
    cfg_data     = '0;
    start        = 1'b0;
    result_ready = 1'b1;
    for (int i = 0; i < 256; i++) fs[i] = 9'(i);
    repeat (2) @(negedge gbdt_clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", result_valid); end
    checks++; if (result !== 19'sd0) begin errors++; $display("FAIL reset_result got %0d exp 0", result); end
    checks++; if (features_nums !== 64'h0) begin errors++; $display("FAIL reset_feat got %h exp 0", features_nums); end
    gbdt_rst_n = 1'b1;
    @(negedge gbdt_clk);
    run_eval(res, lat, bcnt);
    checks++; if (res !== 19'sd0) begin errors++; $display("FAIL zero_result got %0d exp 0", res); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL zero_latency got %0d exp 5", lat); end
    checks++; if (bcnt !== 5) begin errors++; $display("FAIL zero_busy_cycles got %0d exp 5", bcnt); end
    @(negedge gbdt_clk);
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL zero_valid_pulse got %0b exp 0", result_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_idle_busy got %0b exp 0", busy); end
  endtask

  task automatic test_all_left();
    logic signed [18:0] res;
    int lat, bcnt;
    int lp [4] = '{0, 1, 3, 7};
    for (int t = 0; t < 8; t++) begin
      for (int n = 0; n < 15; n++) node_write(t, n, t * 16 + n, 9'h1FF);
      leaf_write(t, 0, t + 1);
    end
    run_eval(res, lat, bcnt);
    checks++; if (res !== 19'sd36) begin errors++; $display("FAIL left_result got %0d exp 36", res); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL left_latency got %0d exp 5", lat); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (feat_hist[j][0] !== 8'(lp[j])) begin
        errors++; $display("FAIL left_feat_t0_lvl%0d got %0d exp %0d", j, feat_hist[j][0], lp[j]);
      end
      checks++;
      if (feat_hist[j][5] !== 8'(80 + lp[j])) begin
        errors++; $display("FAIL left_feat_t5_lvl%0d got %0d exp %0d", j, feat_hist[j][5], 80 + lp[j]);
      end
    end
    @(negedge gbdt_clk);
  endtask

  task automatic test_all_right();
    logic signed [18:0] res;
    int lat, bcnt;
    int rp [4] = '{0, 2, 6, 14};
    for (int t = 0; t < 8; t++) begin
      for (int n = 0; n < 15; n++) node_write(t, n, t * 16 + n, 0);
      leaf_write(t, 15, -100);
    end
    for (int i = 0; i < 256; i++) fs[i] = 9'd1;
    run_eval(res, lat, bcnt);
    checks++; if (res !== -19'sd800) begin errors++; $display("FAIL right_result got %0d exp -800", res); end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (feat_hist[j][0] !== 8'(rp[j])) begin
        errors++; $display("FAIL right_feat_t0_lvl%0d got %0d exp %0d", j, feat_hist[j][0], rp[j]);
      end
    end
    @(negedge gbdt_clk);
  endtask

  task automatic test_threshold_equal();
    logic signed [18:0] res;
    int lat, bcnt;
    gbdt_rst_n = 1'b0;
    @(negedge gbdt_clk);
    gbdt_rst_n = 1'b1;
    @(negedge gbdt_clk);
    setup_equal();
    run_eval(res, lat, bcnt);
    checks++; if (res !== 19'sd1200) begin errors++; $display("FAIL equal_result got %0d exp 1200", res); end
    @(negedge gbdt_clk);
  endtask

  task automatic test_backpressure();
    logic signed [18:0] res;
    int lat, bcnt;
    bit seen;
    result_ready = 1'b0;
    start = 1'b1;
    @(negedge gbdt_clk);
    start = 1'b0;
    @(negedge gbdt_clk);
    // Mid-WALK: both must be ignored.
    start    = 1'b1;
    cfg_we   = 1'b1;
    cfg_leaf = 1'b1;
    cfg_tree = 3'd0;
    cfg_addr = 4'd0;
    cfg_data = 17'd999;
    @(negedge gbdt_clk);
    start  = 1'b0;
    cfg_we = 1'b0;
    seen = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (result_valid) begin seen = 1'b1; break; end
      @(negedge gbdt_clk);
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL bp_valid_seen got %0b exp 1", seen); end
    for (int k = 0; k < 10; k++) begin
      start = (k == 3);
      @(negedge gbdt_clk);
      checks++;
      if (result_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid_%0d got %0b exp 1", k, result_valid); end
      checks++;
      if (result !== 19'sd1200) begin errors++; $display("FAIL bp_hold_result_%0d got %0d exp 1200", k, result); end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL bp_hold_busy_%0d got %0b exp 0", k, busy); end
    end
    // Start coincident with the handshake is ignored.
    result_ready = 1'b1;
    start        = 1'b1;
    @(negedge gbdt_clk);
    start = 1'b0;
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %0b exp 0", result_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_handshake_start got busy %0b exp 0", busy); end
    run_eval(res, lat, bcnt);
    checks++; if (res !== 19'sd1200) begin errors++; $display("FAIL bp_rerun_result got %0d exp 1200", res); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL bp_rerun_latency got %0d exp 5", lat); end
    @(negedge gbdt_clk);
  endtask

  task automatic test_reset_mid_walk();
    logic signed [18:0] res;
    int lat, bcnt;
    start = 1'b1;
    @(negedge gbdt_clk);
    start = 1'b0;
    repeat (2) @(negedge gbdt_clk);
    gbdt_rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_walk_busy got %0b exp 0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_walk_valid got %0b exp 0", result_valid); end
    checks++; if (result !== 19'sd0) begin errors++; $display("FAIL rst_walk_result got %0d exp 0", result); end
    @(negedge gbdt_clk);
    gbdt_rst_n = 1'b1;
    @(negedge gbdt_clk);
    run_eval(res, lat, bcnt);
    checks++; if (res !== 19'sd0) begin errors++; $display("FAIL rst_tables_cleared got %0d exp 0", res); end
    @(negedge gbdt_clk);
    setup_equal();
    run_eval(res, lat, bcnt);
    checks++; if (res !== 19'sd1200) begin errors++; $display("FAIL rst_reload_result got %0d exp 1200", res); end
    @(negedge gbdt_clk);
  endtask

  initial begin
    test_reset();
    test_all_left();
    test_all_right();
    test_threshold_equal();
    test_backpressure();
    test_reset_mid_walk();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
